hazard_ctrl_v2: RTL and testbench
=================================

Name: hazard_ctrl_v2

Overview:
Parametrised successor to the pipeline hazard unit. It sits beside the 5-stage datapath and drives all stall, freeze, bubble and flush controls from ID/EX/MEM/WB state and the I/D memory ready flags. New relative to the previous generation:
- register-address width and retry window are generic
- an explicit I-fetch miss FSM (fetch redirects are latched, not lost, while a miss is outstanding)
- saturating performance counters

Parameters:
REG_ADDR_W, 2, register specifier width (number of registers = 2**REG_ADDR_W)
DATA_FORWARDING, 1, 1 = EX/MEM forwarding present; only the load-use check at EX stalls ID
RF_SELF_FORWARDING, 1, 1 = RF write-through; WB-stage hazards ignored
IFETCH_RETRY, 2, cycles i_mem_read is held low after a fetch miss before re-issue (0..15)
PERF_W, 16, performance counter width

Ports:
clk  in  1  clock
reset  in  1  reset
use_rs, use_rt, use_rs_at_id  in  1 each  ID operand usage from decode (use_rs_at_id = JPR/JRL)
rs_id, rt_id  in  REG_ADDR_W each  ID source registers
reg_write_ex, reg_write_mem, reg_write_wb  in  1 each  stage writes RF
write_reg_ex, write_reg_mem, write_reg_wb  in  REG_ADDR_W each  stage destination registers
d_mem_read_ex, d_mem_read_mem, d_mem_write_mem  in  1 each  stage memory operation
d_ready  in  1  D-memory access complete this cycle
i_ready  in  1  I-memory returned a word this cycle
jump_miss, branch_miss  in  1 each  redirect requests
pc_write, ir_write, i_mem_read  out  1 each
bubblify_id, bubblify_mem, flush_if, freeze_ex, freeze_mem  out  1 each
incr_num_inst  out  1  retire-count enable
redirect_pending  out  1  redirect latched during a fetch miss
stall_cycles, flush_count  out  PERF_W each  saturating counters

Behaviour:
Interface: one clock; reset is synchronous and active-high.

- Reset: FSM=F_RUN, retry counter=0, perf counters=0. While reset=1 these outputs are 0: pc_write, ir_write, i_mem_read, all bubble/freeze/flush signals, incr_num_inst, redirect_pending.

Decision priority (single cycle, combinational from inputs and state):
1. MEM stall: (d_mem_read_mem|d_mem_write_mem)&!d_ready.
   - Drive pc_write=0, ir_write=0, freeze_ex=1, freeze_mem=1, bubblify_mem=1.
2. ID stall: pc_write=0, ir_write=0, bubblify_id=1. Triggers:
   - load-use: d_mem_read_ex & (use_rs & rs_id==write_reg_ex | use_rt & rt_id==write_reg_ex). Always active.
   - if !DATA_FORWARDING: RAW vs EX and MEM writers.
   - if !RF_SELF_FORWARDING: RAW vs WB writer.
   - use_rs_at_id: rs RAW vs EX/MEM writers, regardless of DATA_FORWARDING.
3. Control, only if no stall:
   - jump_miss -> flush_if=1.
   - branch_miss -> flush_if=1, bubblify_id=1.

Fetch FSM (overlays the decisions above; stalls 1/2 suppress redirects):
- F_RUN: i_mem_read=1.
  - If ir_write & !i_ready: pc_write=0, flush_if=1, retry counter=0, next state F_MISS.
- F_MISS:
  - i_mem_read=0 while counter<IFETCH_RETRY, else 1. Counter increments and saturates at 15.
  - pc_write=0, flush_if=1 until i_ready.
  - i_ready & no redirect -> F_RUN; that word is accepted normally.
  - Redirect (jump_miss|branch_miss) in F_MISS: pc_write=1 that cycle, redirect_pending=1, next state F_DROP.
  - If i_ready and a redirect occur in the same cycle, the redirect wins and the word is dropped.
- F_DROP: redirect_pending=1, pc_write=0, flush_if=1, i_mem_read=1.
  - On i_ready the stale word is discarded, next state F_RUN.
  - Further redirects in F_DROP: pc_write=1, stay in F_DROP.

Outputs and counters:
- incr_num_inst = !(bubblify_id|bubblify_mem|!pc_write|flush_if).
- stall_cycles increments on any cycle with pc_write=0.
- flush_count increments on any cycle with flush_if=1 caused by a redirect or a drop (not by miss waiting).
- Both counters saturate at all-ones.
- Reset asserted mid-miss: the FSM returns to F_RUN on the next edge and any pending redirect is discarded.

Decomposition:
- Shared package/header: FSM state encoding (F_RUN=0, F_MISS=1, F_DROP=2, 2 bits), INSTTYPE/OPCODE constants already in the codebase, WORD_SIZE.
- One natural sub-module: hazard_raw_check (combinational RAW/load-use comparator, parametrised by REG_ADDR_W and the forwarding flags), instantiated once.

Test Plan:
- Load-use: d_mem_read_ex=1, write_reg_ex=2, use_rs=1, rs_id=2 -> pc_write=0, ir_write=0, bubblify_id=1, incr_num_inst=0 for 1 cycle; stall_cycles=1.
- MEM stall vs branch: d_mem_read_mem=1, d_ready=0 for 3 cycles, branch_miss=1 -> freeze_ex=freeze_mem=bubblify_mem=1 and flush_if=0 all 3 cycles; stall_cycles=3.
- I-miss retry, IFETCH_RETRY=2: i_ready low for 5 cycles -> i_mem_read pattern 1,0,0,1,1,1; i_ready on cycle 5 returns FSM to F_RUN; flush_count unchanged.
- Redirect during miss: jump_miss pulse in miss cycle 2 -> pc_write=1 that cycle, redirect_pending=1 until i_ready, next returned word flushed, flush_count=1.
- Parameter sweep REG_ADDR_W=3, DATA_FORWARDING=0: reg_write_mem=1, write_reg_mem=7, use_rt=1, rt_id=7 -> bubblify_id=1; with write_reg_mem=3 -> no stall.
- Saturation and reset: PERF_W=4, 20 stall cycles -> stall_cycles=15; reset in F_DROP -> FSM=F_RUN, counters=0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl_v2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_v2_pkg
//  Description : Shared types and constants for the pipeline hazard unit:
//                fetch FSM state encoding, retry counter sizing and the
//                datapath instruction constants already used elsewhere.
//  Revision    : 2.0 - parametrised successor with fetch-miss FSM
// ============================================================================
package hazard_ctrl_v2_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        F_RUN  = 2'd0,
        F_MISS = 2'd1,
        F_DROP = 2'd2
    } fetch_state_e;

    localparam int WORD_SIZE = 16;

    // Retry counter saturates at 15, which bounds IFETCH_RETRY to 0..15
    localparam int                     RETRY_CNT_W   = 4;
    localparam logic [RETRY_CNT_W-1:0] RETRY_CNT_MAX = 4'd15;

    // Instruction type / opcode constants shared with the datapath
    localparam logic [1:0] INSTTYPE_ALU    = 2'd0;
    localparam logic [1:0] INSTTYPE_MEM    = 2'd1;
    localparam logic [1:0] INSTTYPE_BRANCH = 2'd2;
    localparam logic [1:0] INSTTYPE_JUMP   = 2'd3;

    localparam logic [3:0] OPCODE_BNE   = 4'd0;
    localparam logic [3:0] OPCODE_LWD   = 4'd7;
    localparam logic [3:0] OPCODE_SWD   = 4'd8;
    localparam logic [3:0] OPCODE_JMP   = 4'd9;
    localparam logic [3:0] OPCODE_RTYPE = 4'd15;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_v2_raw_check.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_raw_check
//  Description : Combinational RAW / load-use comparator. Raises id_stall
//                when the instruction in ID must wait for an older writer.
//  Revision    : 2.0 - forwarding options selected at elaboration
// ============================================================================
module hazard_raw_check #(
    parameter int REG_ADDR_W         = 2,
    parameter int DATA_FORWARDING    = 1,
    parameter int RF_SELF_FORWARDING = 1
) (
    input  logic                  use_rs,
    input  logic                  use_rt,
    input  logic                  use_rs_at_id,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  reg_write_ex,
    input  logic                  reg_write_mem,
    input  logic                  reg_write_wb,
    input  logic [REG_ADDR_W-1:0] write_reg_ex,
    input  logic [REG_ADDR_W-1:0] write_reg_mem,
    input  logic [REG_ADDR_W-1:0] write_reg_wb,
    input  logic                  d_mem_read_ex,
    output logic                  id_stall
);

    logic rs_eq_ex;
    logic rs_eq_mem;
    logic rt_eq_ex;
    logic reads_ex;
    logic load_use;
    logic raw_exmem;
    logic raw_wb;
    logic raw_jr;

    assign rs_eq_ex  = (rs_id == write_reg_ex);
    assign rs_eq_mem = (rs_id == write_reg_mem);
    assign rt_eq_ex  = (rt_id == write_reg_ex);
    assign reads_ex  = (use_rs & rs_eq_ex) | (use_rt & rt_eq_ex);

    // A load in EX cannot be forwarded in time, so it always stalls a reader
    assign load_use = d_mem_read_ex & reads_ex;

    // Register-indirect jumps consume rs in ID, ahead of any forwarding path
    assign raw_jr = use_rs_at_id & ((reg_write_ex & rs_eq_ex) | (reg_write_mem & rs_eq_mem));

    generate
        if (DATA_FORWARDING == 0) begin : g_raw_exmem
            logic reads_mem;
            assign reads_mem = (use_rs & rs_eq_mem) | (use_rt & (rt_id == write_reg_mem));
            assign raw_exmem = (reg_write_ex & reads_ex) | (reg_write_mem & reads_mem);
        end else begin : g_fwd_exmem
            assign raw_exmem = 1'b0;
        end
    endgenerate

    generate
        if (RF_SELF_FORWARDING == 0) begin : g_raw_wb
            assign raw_wb = reg_write_wb &
                            ((use_rs & (rs_id == write_reg_wb)) | (use_rt & (rt_id == write_reg_wb)));
        end else begin : g_wt_wb
            logic unused_wb;
            assign unused_wb = ^{reg_write_wb, write_reg_wb};
            assign raw_wb    = 1'b0;
        end
    endgenerate

    assign id_stall = load_use | raw_exmem | raw_wb | raw_jr;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_v2
//  Description : Pipeline hazard unit for the 5-stage datapath. Drives stall,
//                freeze, bubble and flush controls, runs the I-fetch miss FSM
//                and keeps saturating stall / flush counters.
//  Revision    : 2.0 - generic widths, fetch-miss FSM, perf counters
// ============================================================================
module hazard_ctrl_v2 #(
    parameter int REG_ADDR_W         = 2,
    parameter int DATA_FORWARDING    = 1,
    parameter int RF_SELF_FORWARDING = 1,
    parameter int IFETCH_RETRY       = 2,
    parameter int PERF_W             = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  use_rs,
    input  logic                  use_rt,
    input  logic                  use_rs_at_id,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic                  reg_write_ex,
    input  logic                  reg_write_mem,
    input  logic                  reg_write_wb,
    input  logic [REG_ADDR_W-1:0] write_reg_ex,
    input  logic [REG_ADDR_W-1:0] write_reg_mem,
    input  logic [REG_ADDR_W-1:0] write_reg_wb,
    input  logic                  d_mem_read_ex,
    input  logic                  d_mem_read_mem,
    input  logic                  d_mem_write_mem,
    input  logic                  d_ready,
    input  logic                  i_ready,
    input  logic                  jump_miss,
    input  logic                  branch_miss,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  i_mem_read,
    output logic                  bubblify_id,
    output logic                  bubblify_mem,
    output logic                  flush_if,
    output logic                  freeze_ex,
    output logic                  freeze_mem,
    output logic                  incr_num_inst,
    output logic                  redirect_pending,
    output logic [PERF_W-1:0]     stall_cycles,
    output logic [PERF_W-1:0]     flush_count
);

    import hazard_ctrl_v2_pkg::*;

    localparam logic [RETRY_CNT_W-1:0] RETRY_LIM = RETRY_CNT_W'(IFETCH_RETRY);

    fetch_state_e           state;
    fetch_state_e           next_state;
    logic [RETRY_CNT_W-1:0] retry_cnt;
    logic [RETRY_CNT_W-1:0] next_retry;

    logic id_stall;
    logic mem_stall;
    logic redirect;
    logic flush_event;

    logic pc_write_int;
    logic ir_write_int;
    logic i_mem_read_int;
    logic bubblify_id_int;
    logic bubblify_mem_int;
    logic flush_if_int;
    logic freeze_ex_int;
    logic freeze_mem_int;
    logic pending_int;

    hazard_raw_check #(
        .REG_ADDR_W         (REG_ADDR_W),
        .DATA_FORWARDING    (DATA_FORWARDING),
        .RF_SELF_FORWARDING (RF_SELF_FORWARDING)
    ) u_raw_check (
        .use_rs        (use_rs),
        .use_rt        (use_rt),
        .use_rs_at_id  (use_rs_at_id),
        .rs_id         (rs_id),
        .rt_id         (rt_id),
        .reg_write_ex  (reg_write_ex),
        .reg_write_mem (reg_write_mem),
        .reg_write_wb  (reg_write_wb),
        .write_reg_ex  (write_reg_ex),
        .write_reg_mem (write_reg_mem),
        .write_reg_wb  (write_reg_wb),
        .d_mem_read_ex (d_mem_read_ex),
        .id_stall      (id_stall)
    );

    assign mem_stall = (d_mem_read_mem | d_mem_write_mem) & ~d_ready;
    // Any pipeline stall holds the redirecting instruction, so it is not acted on yet
    assign redirect  = (jump_miss | branch_miss) & ~mem_stall & ~id_stall;

    // Fetch state and retry counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= F_RUN;
            retry_cnt <= '0;
        end else begin
            state     <= next_state;
            retry_cnt <= next_retry;
        end
    end

    // Stall/control priority first, then the fetch FSM overlays its overrides
    always_comb begin
        pc_write_int     = 1'b1;
        ir_write_int     = 1'b1;
        i_mem_read_int   = 1'b1;
        bubblify_id_int  = 1'b0;
        bubblify_mem_int = 1'b0;
        flush_if_int     = 1'b0;
        freeze_ex_int    = 1'b0;
        freeze_mem_int   = 1'b0;
        pending_int      = 1'b0;
        flush_event      = 1'b0;
        next_state       = state;
        next_retry       = retry_cnt;

        if (mem_stall) begin
            pc_write_int     = 1'b0;
            ir_write_int     = 1'b0;
            freeze_ex_int    = 1'b1;
            freeze_mem_int   = 1'b1;
            bubblify_mem_int = 1'b1;
        end else if (id_stall) begin
            pc_write_int    = 1'b0;
            ir_write_int    = 1'b0;
            bubblify_id_int = 1'b1;
        end else begin
            flush_if_int    = jump_miss | branch_miss;
            bubblify_id_int = branch_miss;
        end

        case (state)
            F_RUN: begin
                flush_event = redirect;
                if (ir_write_int && !i_ready) begin
                    pc_write_int = 1'b0;
                    flush_if_int = 1'b1;
                    next_retry   = '0;
                    next_state   = F_MISS;
                end
            end
            F_MISS: begin
                i_mem_read_int = (retry_cnt >= RETRY_LIM);
                if (retry_cnt != RETRY_CNT_MAX) begin
                    next_retry = retry_cnt + RETRY_CNT_W'(1);
                end
                if (redirect) begin
                    // Take the new PC now; the word still in flight is stale
                    pc_write_int = 1'b1;
                    flush_if_int = 1'b1;
                    pending_int  = 1'b1;
                    next_state   = F_DROP;
                end else if (!i_ready) begin
                    pc_write_int = 1'b0;
                    flush_if_int = 1'b1;
                end else begin
                    next_state = F_RUN;
                end
            end
            F_DROP: begin
                pending_int    = 1'b1;
                flush_if_int   = 1'b1;
                i_mem_read_int = 1'b1;
                pc_write_int   = redirect;
                // The stale word arriving is the one drop that gets counted
                flush_event    = i_ready;
                if (!redirect && i_ready) begin
                    next_state = F_RUN;
                end
            end
            default: begin
                next_state = F_RUN;
                next_retry = '0;
            end
        endcase
    end

    assign pc_write         = ~reset & pc_write_int;
    assign ir_write         = ~reset & ir_write_int;
    assign i_mem_read       = ~reset & i_mem_read_int;
    assign bubblify_id      = ~reset & bubblify_id_int;
    assign bubblify_mem     = ~reset & bubblify_mem_int;
    assign flush_if         = ~reset & flush_if_int;
    assign freeze_ex        = ~reset & freeze_ex_int;
    assign freeze_mem       = ~reset & freeze_mem_int;
    assign redirect_pending = ~reset & pending_int;
    assign incr_num_inst    = ~reset & ~(bubblify_id_int | bubblify_mem_int | ~pc_write_int | flush_if_int);

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write_int && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
            if (flush_event && (flush_count != '1)) begin
                flush_count <= flush_count + PERF_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl_v2
//  Description : Self-checking bench for hazard_ctrl_v2. Two instances with
//                different parameter sets share one stimulus stream and are
//                compared against a behavioural model every cycle.
//  Revision    : 2.0
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_ctrl_v2;

    typedef struct packed {
        logic       reset;
        logic       use_rs;
        logic       use_rt;
        logic       use_rs_at_id;
        logic [2:0] rs_id;
        logic [2:0] rt_id;
        logic       reg_write_ex;
        logic       reg_write_mem;
        logic       reg_write_wb;
        logic [2:0] write_reg_ex;
        logic [2:0] write_reg_mem;
        logic [2:0] write_reg_wb;
        logic       d_mem_read_ex;
        logic       d_mem_read_mem;
        logic       d_mem_write_mem;
        logic       d_ready;
        logic       i_ready;
        logic       jump_miss;
        logic       branch_miss;
    } stim_t;

    typedef struct packed {
        logic miss;
        logic drop;
        int   wait_cnt;
        int   stalls;
        int   flushes;
    } mstate_t;

    logic    clk = 1'b0;
    stim_t   s;
    stim_t   x;
    mstate_t ma;
    mstate_t mb;
    int      tests = 0;
    int      fails = 0;
    logic [5:0] pat;

    always #5 clk = ~clk;

    logic a_pc_write, a_ir_write, a_i_mem_read, a_bubblify_id, a_bubblify_mem, a_flush_if;
    logic a_freeze_ex, a_freeze_mem, a_incr_num_inst, a_redirect_pending;
    logic [15:0] a_stall_cycles, a_flush_count;
    logic b_pc_write, b_ir_write, b_i_mem_read, b_bubblify_id, b_bubblify_mem, b_flush_if;
    logic b_freeze_ex, b_freeze_mem, b_incr_num_inst, b_redirect_pending;
    logic [3:0] b_stall_cycles, b_flush_count;
    logic [9:0] a_vec, b_vec;

    assign a_vec = {a_pc_write, a_ir_write, a_i_mem_read, a_bubblify_id, a_bubblify_mem,
                    a_flush_if, a_freeze_ex, a_freeze_mem, a_incr_num_inst, a_redirect_pending};
    assign b_vec = {b_pc_write, b_ir_write, b_i_mem_read, b_bubblify_id, b_bubblify_mem,
                    b_flush_if, b_freeze_ex, b_freeze_mem, b_incr_num_inst, b_redirect_pending};

    hazard_ctrl_v2 #(
        .REG_ADDR_W(2), .DATA_FORWARDING(1), .RF_SELF_FORWARDING(1), .IFETCH_RETRY(2), .PERF_W(16)
    ) dut_a (
        .clk(clk), .reset(s.reset),
        .use_rs(s.use_rs), .use_rt(s.use_rt), .use_rs_at_id(s.use_rs_at_id),
        .rs_id(s.rs_id[1:0]), .rt_id(s.rt_id[1:0]),
        .reg_write_ex(s.reg_write_ex), .reg_write_mem(s.reg_write_mem), .reg_write_wb(s.reg_write_wb),
        .write_reg_ex(s.write_reg_ex[1:0]), .write_reg_mem(s.write_reg_mem[1:0]),
        .write_reg_wb(s.write_reg_wb[1:0]),
        .d_mem_read_ex(s.d_mem_read_ex), .d_mem_read_mem(s.d_mem_read_mem),
        .d_mem_write_mem(s.d_mem_write_mem), .d_ready(s.d_ready), .i_ready(s.i_ready),
        .jump_miss(s.jump_miss), .branch_miss(s.branch_miss),
        .pc_write(a_pc_write), .ir_write(a_ir_write), .i_mem_read(a_i_mem_read),
        .bubblify_id(a_bubblify_id), .bubblify_mem(a_bubblify_mem), .flush_if(a_flush_if),
        .freeze_ex(a_freeze_ex), .freeze_mem(a_freeze_mem), .incr_num_inst(a_incr_num_inst),
        .redirect_pending(a_redirect_pending), .stall_cycles(a_stall_cycles),
        .flush_count(a_flush_count)
    );

    hazard_ctrl_v2 #(
        .REG_ADDR_W(3), .DATA_FORWARDING(0), .RF_SELF_FORWARDING(0), .IFETCH_RETRY(3), .PERF_W(4)
    ) dut_b (
        .clk(clk), .reset(s.reset),
        .use_rs(s.use_rs), .use_rt(s.use_rt), .use_rs_at_id(s.use_rs_at_id),
        .rs_id(s.rs_id), .rt_id(s.rt_id),
        .reg_write_ex(s.reg_write_ex), .reg_write_mem(s.reg_write_mem), .reg_write_wb(s.reg_write_wb),
        .write_reg_ex(s.write_reg_ex), .write_reg_mem(s.write_reg_mem), .write_reg_wb(s.write_reg_wb),
        .d_mem_read_ex(s.d_mem_read_ex), .d_mem_read_mem(s.d_mem_read_mem),
        .d_mem_write_mem(s.d_mem_write_mem), .d_ready(s.d_ready), .i_ready(s.i_ready),
        .jump_miss(s.jump_miss), .branch_miss(s.branch_miss),
        .pc_write(b_pc_write), .ir_write(b_ir_write), .i_mem_read(b_i_mem_read),
        .bubblify_id(b_bubblify_id), .bubblify_mem(b_bubblify_mem), .flush_if(b_flush_if),
        .freeze_ex(b_freeze_ex), .freeze_mem(b_freeze_mem), .incr_num_inst(b_incr_num_inst),
        .redirect_pending(b_redirect_pending), .stall_cycles(b_stall_cycles),
        .flush_count(b_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: one cycle of the hazard rules for a given configuration
    task automatic model(input int aw, input bit df, input bit rsf, input int retry, input int pw,
                         input stim_t t, inout mstate_t st, output logic [9:0] exp);
        int m, rs, rt, wex, wmem, wwb, cap;
        bit hit_ex, hit_mem, hit_wb, idh, memh, redir, counted;
        bit pc, ir, imr, bid, bmem, fl, fex, fmem, pend;
        m    = (1 << aw) - 1;
        cap  = (1 << pw) - 1;
        rs   = int'(t.rs_id) & m;
        rt   = int'(t.rt_id) & m;
        wex  = int'(t.write_reg_ex) & m;
        wmem = int'(t.write_reg_mem) & m;
        wwb  = int'(t.write_reg_wb) & m;
        if (t.reset) begin
            exp = '0;
            st  = '0;
            return;
        end
        hit_ex  = (t.use_rs && rs == wex)  || (t.use_rt && rt == wex);
        hit_mem = (t.use_rs && rs == wmem) || (t.use_rt && rt == wmem);
        hit_wb  = (t.use_rs && rs == wwb)  || (t.use_rt && rt == wwb);
        idh  = (t.d_mem_read_ex && hit_ex)
            || (!df && ((t.reg_write_ex && hit_ex) || (t.reg_write_mem && hit_mem)))
            || (!rsf && t.reg_write_wb && hit_wb)
            || (t.use_rs_at_id && ((t.reg_write_ex && rs == wex) || (t.reg_write_mem && rs == wmem)));
        memh  = (t.d_mem_read_mem || t.d_mem_write_mem) && !t.d_ready;
        redir = (t.jump_miss || t.branch_miss) && !memh && !idh;
        pc = 1; ir = 1; imr = 1; bid = 0; bmem = 0; fl = 0; fex = 0; fmem = 0; pend = 0;
        counted = 0;
        if (memh) begin
            pc = 0; ir = 0; fex = 1; fmem = 1; bmem = 1;
        end else if (idh) begin
            pc = 0; ir = 0; bid = 1;
        end else begin
            fl  = t.jump_miss || t.branch_miss;
            bid = t.branch_miss;
        end
        if (st.drop) begin
            pend = 1; fl = 1; imr = 1; pc = redir;
            counted = t.i_ready;
            if (!redir && t.i_ready) st.drop = 0;
        end else if (st.miss) begin
            imr = (st.wait_cnt >= retry);
            st.wait_cnt = (st.wait_cnt < 15) ? st.wait_cnt + 1 : 15;
            if (redir) begin
                pc = 1; fl = 1; pend = 1;
                st.miss = 0; st.drop = 1;
            end else if (!t.i_ready) begin
                pc = 0; fl = 1;
            end else begin
                st.miss = 0;
            end
        end else begin
            counted = redir;
            if (ir && !t.i_ready) begin
                pc = 0; fl = 1;
                st.miss = 1; st.wait_cnt = 0;
            end
        end
        exp = {pc, ir, imr, bid, bmem, fl, fex, fmem, !(bid || bmem || !pc || fl), pend};
        if (!pc && st.stalls < cap) st.stalls = st.stalls + 1;
        if (counted && st.flushes < cap) st.flushes = st.flushes + 1;
    endtask

    // Apply one cycle of stimulus and compare both instances against the model
    task automatic step(input stim_t t);
        logic [9:0] ea, eb;
        int sa, fa, sb, fb;
        @(posedge clk);
        #1;
        s = t;
        @(negedge clk);
        sa = ma.stalls; fa = ma.flushes;
        sb = mb.stalls; fb = mb.flushes;
        model(2, 1'b1, 1'b1, 2, 16, t, ma, ea);
        model(3, 1'b0, 1'b0, 3, 4, t, mb, eb);
        chk("a_ctrl",  32'(a_vec), 32'(ea));
        chk("a_stall", 32'(a_stall_cycles), sa);
        chk("a_flush", 32'(a_flush_count), fa);
        chk("b_ctrl",  32'(b_vec), 32'(eb));
        chk("b_stall", 32'(b_stall_cycles), sb);
        chk("b_flush", 32'(b_flush_count), fb);
    endtask

    function automatic stim_t idle();
        stim_t t;
        t = '0;
        t.d_ready = 1'b1;
        t.i_ready = 1'b1;
        return t;
    endfunction

    function automatic stim_t rand_stim();
        stim_t t;
        t = '0;
        t.reset           = ($urandom_range(0, 59) == 0);
        t.use_rs          = 1'($urandom_range(0, 1));
        t.use_rt          = 1'($urandom_range(0, 1));
        t.use_rs_at_id    = ($urandom_range(0, 5) == 0);
        t.rs_id           = 3'($urandom_range(0, 7));
        t.rt_id           = 3'($urandom_range(0, 7));
        t.reg_write_ex    = 1'($urandom_range(0, 1));
        t.reg_write_mem   = 1'($urandom_range(0, 1));
        t.reg_write_wb    = 1'($urandom_range(0, 1));
        t.write_reg_ex    = 3'($urandom_range(0, 7));
        t.write_reg_mem   = 3'($urandom_range(0, 7));
        t.write_reg_wb    = 3'($urandom_range(0, 7));
        t.d_mem_read_ex   = ($urandom_range(0, 3) == 0);
        t.d_mem_read_mem  = ($urandom_range(0, 3) == 0);
        t.d_mem_write_mem = ($urandom_range(0, 5) == 0);
        t.d_ready         = ($urandom_range(0, 4) != 0);
        t.i_ready         = ($urandom_range(0, 2) != 0);
        t.jump_miss       = ($urandom_range(0, 7) == 0);
        t.branch_miss     = ($urandom_range(0, 7) == 0);
        return t;
    endfunction

    task automatic do_reset();
        stim_t t;
        t = idle();
        t.reset = 1'b1;
        step(t);
    endtask

    initial begin
        ma = '0;
        mb = '0;
        x = idle();
        x.reset = 1'b1;
        s = x;

        // Reset state
        do_reset();
        chk("rst_outputs_a", 32'(a_vec), 32'(0));
        chk("rst_outputs_b", 32'(b_vec), 32'(0));
        step(idle());
        chk("rst_stall_cnt", 32'(a_stall_cycles), 32'(0));
        chk("idle_ctrl", 32'(a_vec), 32'(10'b1110000010));

        // Load-use stall for one cycle
        x = idle();
        x.d_mem_read_ex = 1'b1; x.write_reg_ex = 3'd2; x.use_rs = 1'b1; x.rs_id = 3'd2;
        step(x);
        chk("lu_ctrl", 32'({a_pc_write, a_ir_write, a_bubblify_id, a_incr_num_inst}), 32'(4'b0010));
        step(idle());
        chk("lu_stall_cnt", 32'(a_stall_cycles), 32'(1));

        // MEM stall outranks a branch miss
        do_reset();
        for (int i = 0; i < 3; i++) begin
            x = idle();
            x.d_mem_read_mem = 1'b1; x.d_ready = 1'b0; x.branch_miss = 1'b1;
            step(x);
            chk("memstall_ctrl", 32'({a_freeze_ex, a_freeze_mem, a_bubblify_mem, a_flush_if}),
                32'(4'b1110));
        end
        step(idle());
        chk("memstall_cnt", 32'(a_stall_cycles), 32'(3));

        // I-fetch miss with retry window of 2
        do_reset();
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            x = idle();
            x.i_ready = (i == 5);
            step(x);
            pat = {pat[4:0], a_i_mem_read};
        end
        chk("imiss_pattern", 32'(pat), 32'(6'b100111));
        step(idle());
        chk("imiss_back_run", 32'({a_pc_write, a_flush_if}), 32'(2'b10));
        chk("imiss_flush_cnt", 32'(a_flush_count), 32'(0));

        // Redirect during a miss is latched and the next word dropped
        do_reset();
        x = idle(); x.i_ready = 1'b0;
        step(x);
        step(x);
        x.jump_miss = 1'b1;
        step(x);
        chk("redir_take", 32'({a_pc_write, a_redirect_pending}), 32'(2'b11));
        x.jump_miss = 1'b0;
        step(x);
        chk("redir_hold", 32'({a_pc_write, a_flush_if, a_redirect_pending}), 32'(3'b011));
        x.i_ready = 1'b1;
        step(x);
        chk("redir_drop", 32'({a_pc_write, a_flush_if, a_redirect_pending, a_incr_num_inst}),
            32'(4'b0110));
        step(idle());
        chk("redir_clear", 32'(a_redirect_pending), 32'(0));
        chk("redir_flush_cnt", 32'(a_flush_count), 32'(1));

        // Wider register file without forwarding
        do_reset();
        x = idle();
        x.reg_write_mem = 1'b1; x.write_reg_mem = 3'd7; x.use_rt = 1'b1; x.rt_id = 3'd7;
        step(x);
        chk("nofwd_stall", 32'(b_bubblify_id), 32'(1));
        chk("fwd_nostall", 32'(a_bubblify_id), 32'(0));
        x.write_reg_mem = 3'd3;
        step(x);
        chk("nofwd_other_reg", 32'(b_bubblify_id), 32'(0));

        // Counter saturation, then reset while a drop is pending
        do_reset();
        x = idle();
        x.d_mem_read_ex = 1'b1; x.use_rs = 1'b1;
        repeat (20) step(x);
        step(idle());
        chk("sat_stall_b", 32'(b_stall_cycles), 32'(15));
        chk("nosat_stall_a", 32'(a_stall_cycles), 32'(20));
        x = idle(); x.i_ready = 1'b0;
        step(x);
        x.branch_miss = 1'b1;
        step(x);
        x.branch_miss = 1'b0;
        step(x);
        chk("drop_pending", 32'(b_redirect_pending), 32'(1));
        x.reset = 1'b1;
        step(x);
        chk("rst_in_drop", 32'(b_vec), 32'(0));
        step(idle());
        chk("post_rst_run", 32'({b_pc_write, b_redirect_pending}), 32'(2'b10));
        chk("post_rst_stall", 32'(b_stall_cycles), 32'(0));
        chk("post_rst_flush", 32'(b_flush_count), 32'(0));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(rand_stim());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
